// File: rtl/anita3_buffer_hold_scheduler_pkg.sv
// Shared constants for the ANITA-3 trigger-domain buffer scheduler.
// State encoding, buffer geometry and drop counter width.
package anita3_trig_pkg;

    localparam int NBUF          = 4;
    localparam int BUF_BITS      = 2;
    localparam int DROP_CNT_BITS = 16;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DIGITIZE = 2'd1;
    localparam logic [1:0] HOLDOFF  = 2'd2;

endpackage

// File: rtl/anita3_buffer_hold_scheduler_if.sv
// Trigger / digitize bundle between the trigger logic and the scheduler.
// The slave side is the scheduler, the master side is the trigger source.
interface anita3_buffer_hold_scheduler_if;
    import anita3_trig_pkg::*;

    logic                     trig_i;
    logic [3:0]               trig_source_i;
    logic [NBUF-1:0]          clear_i;
    logic                     clr_all_i;
    logic                     digitize_o;
    logic [BUF_BITS-1:0]      digitize_buffer_o;
    logic [3:0]               digitize_source_o;
    logic [NBUF-1:0]          buffer_status_o;
    logic [NBUF-1:0]          holds_o;
    logic                     full_o;
    logic                     busy_o;
    logic [DROP_CNT_BITS-1:0] dropped_count_o;

    modport slave (
        input  trig_i, trig_source_i, clear_i, clr_all_i,
        output digitize_o, digitize_buffer_o, digitize_source_o,
        output buffer_status_o, holds_o, full_o, busy_o, dropped_count_o
    );

    modport master (
        output trig_i, trig_source_i, clear_i, clr_all_i,
        input  digitize_o, digitize_buffer_o, digitize_source_o,
        input  buffer_status_o, holds_o, full_o, busy_o, dropped_count_o
    );

endinterface

// File: rtl/anita3_buffer_hold_scheduler_rr_free_select.sv
// Combinational round-robin free-buffer finder.
// Searches last+1, last+2, ... (mod NBUF) for the first free slot.
module rr_free_select
    import anita3_trig_pkg::*;
(
    input  logic [NBUF-1:0]     free_i,
    input  logic [BUF_BITS-1:0] last_i,
    output logic [BUF_BITS-1:0] sel_o,
    output logic                any_free_o
);

    logic [BUF_BITS-1:0] idx;
    logic                found;

    // Walk the slots after the last allocation, first free one wins
    always_comb begin
        sel_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NBUF; i++) begin
            idx = last_i + BUF_BITS'(i);
            if (!found && free_i[idx]) begin
                sel_o = idx;
                found = 1'b1;
            end
        end
    end

    assign any_free_o = found;

endmodule

// File: rtl/anita3_buffer_hold_scheduler.sv
// Trigger-domain LAB buffer hold scheduler: accepts triggers, allocates
// a free buffer round-robin, strobes digitize and tracks holds/drops.
module anita3_buffer_hold_scheduler
    import anita3_trig_pkg::*;
#(
    parameter int DIG_LEN     = 4,
    parameter int HOLDOFF_LEN = 8
) (
    input logic                          clk125_i,
    input logic                          rst_i,
    anita3_buffer_hold_scheduler_if.slave bus
);

    localparam logic [7:0] DIG_INIT  = 8'(DIG_LEN - 1);
    localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF_LEN - 1);

    logic [1:0]               state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [NBUF-1:0]          holds_q, holds_d;
    logic                     full_q;
    logic [BUF_BITS-1:0]      last_q, last_d;
    logic [BUF_BITS-1:0]      dbuf_q, dbuf_d;
    logic [3:0]               dsrc_q, dsrc_d;
    logic [NBUF-1:0]          bstat_q, bstat_d;
    logic [DROP_CNT_BITS-1:0] drop_q, drop_d;

    logic [NBUF-1:0]          holds_clr;
    logic [NBUF-1:0]          alloc_bit;
    logic [BUF_BITS-1:0]      sel;
    logic                     any_free;
    logic                     accept;

    // Clears take effect before the free search in the same cycle
    assign holds_clr = holds_q & ~bus.clear_i;

    rr_free_select u_sel (
        .free_i     (~holds_clr),
        .last_i     (last_q),
        .sel_o      (sel),
        .any_free_o (any_free)
    );

    assign accept = bus.trig_i && !bus.clr_all_i &&
                    (state_q == IDLE) && any_free;

    // Next-state, allocation, clear and drop bookkeeping
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        dbuf_d    = dbuf_q;
        dsrc_d    = dsrc_q;
        bstat_d   = bstat_q;
        drop_d    = drop_q;
        alloc_bit = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DIGITIZE;
                    cnt_d   = DIG_INIT;
                end
            end
            DIGITIZE: begin
                if (cnt_q == 8'd0) begin
                    if (HOLDOFF_LEN > 0) begin
                        state_d = HOLDOFF;
                        cnt_d   = HOLD_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLDOFF: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            alloc_bit[sel] = 1'b1;
            last_d         = sel;
            dbuf_d         = sel;
            dsrc_d         = bus.trig_source_i;
            bstat_d        = holds_clr;
        end

        if (bus.trig_i && !accept && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
        end

        holds_d = holds_clr | alloc_bit;

        if (bus.clr_all_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            holds_d = '0;
        end
    end

    // State and output registers, synchronous active-high reset
    always_ff @(posedge clk125_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            holds_q <= '0;
            full_q  <= 1'b0;
            last_q  <= BUF_BITS'(NBUF - 1);
            dbuf_q  <= '0;
            dsrc_q  <= '0;
            bstat_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            holds_q <= holds_d;
            full_q  <= &holds_d;
            last_q  <= last_d;
            dbuf_q  <= dbuf_d;
            dsrc_q  <= dsrc_d;
            bstat_q <= bstat_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.digitize_o        = (state_q == DIGITIZE);
    assign bus.digitize_buffer_o = dbuf_q;
    assign bus.digitize_source_o = dsrc_q;
    assign bus.buffer_status_o   = bstat_q;
    assign bus.holds_o           = holds_q;
    assign bus.full_o            = full_q;
    assign bus.busy_o            = (state_q != IDLE);
    assign bus.dropped_count_o   = drop_q;

endmodule

// File: tb/tb_anita3_buffer_hold_scheduler.sv
// Bench for the buffer hold scheduler: timeline model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_anita3_buffer_hold_scheduler;

    localparam int DIG  = 4;
    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic rst;

    anita3_buffer_hold_scheduler_if bus ();

    anita3_buffer_hold_scheduler #(
        .DIG_LEN     (DIG),
        .HOLDOFF_LEN (HOLD)
    ) dut (
        .clk125_i (clk),
        .rst_i    (rst),
        .bus      (bus)
    );

    always #4 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: digitize is high for cycles up to m_dig_end,
    // busy for cycles before m_idle_from.
    int         cyc = 0;
    bit         m_valid = 0;
    logic [3:0] m_holds, m_stat, m_src;
    logic [1:0] m_buf;
    int         m_last;
    int         m_dig_end, m_idle_from;
    logic [15:0] m_drop;

    initial forever begin
        logic [3:0] cl;
        bit         acc, found;
        int         s, t;
        @(posedge clk);
        t = cyc;
        if (rst) begin
            m_valid = 1; m_holds = 0; m_stat = 0; m_src = 0; m_buf = 0;
            m_last = 3; m_drop = 0; m_dig_end = t; m_idle_from = t + 1;
        end else if (m_valid) begin
            cl  = m_holds & ~bus.clear_i;
            acc = bus.trig_i && !bus.clr_all_i && t >= m_idle_from && cl != 4'hF;
            if (acc) begin
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    s = (m_last + k) % 4;
                    if (!found && !cl[s]) begin
                        found = 1; m_last = s;
                    end
                end
                m_buf = 2'(m_last);
                m_src = bus.trig_source_i;
                m_stat = cl;
                cl[m_last] = 1'b1;
                m_dig_end = t + DIG;
                m_idle_from = t + DIG + HOLD + 1;
            end
            if (bus.trig_i && !acc && m_drop != 16'hFFFF) m_drop = m_drop + 1;
            if (bus.clr_all_i) begin
                cl = 0; m_dig_end = t; m_idle_from = t + 1;
            end
            m_holds = cl;
        end
        cyc++;
    end

    // Per-cycle comparison against the model, away from the clock edge
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("m_digitize", 32'(bus.digitize_o), 32'(cyc <= m_dig_end));
            chk("m_busy", 32'(bus.busy_o), 32'(cyc < m_idle_from));
            chk("m_holds", 32'(bus.holds_o), 32'(m_holds));
            chk("m_full", 32'(bus.full_o), 32'(&m_holds));
            chk("m_buffer", 32'(bus.digitize_buffer_o), 32'(m_buf));
            chk("m_source", 32'(bus.digitize_source_o), 32'(m_src));
            chk("m_status", 32'(bus.buffer_status_o), 32'(m_stat));
            chk("m_dropped", 32'(bus.dropped_count_o), 32'(m_drop));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_digitize"}, 32'(bus.digitize_o), 0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 0);
        chk({tag, "_holds"}, 32'(bus.holds_o), 0);
        chk({tag, "_full"}, 32'(bus.full_o), 0);
        chk({tag, "_buffer"}, 32'(bus.digitize_buffer_o), 0);
        chk({tag, "_source"}, 32'(bus.digitize_source_o), 0);
        chk({tag, "_status"}, 32'(bus.buffer_status_o), 0);
        chk({tag, "_dropped"}, 32'(bus.dropped_count_o), 0);
    endtask

    logic [3:0] exp_stat [4];

    initial begin
        exp_stat[0] = 4'b0000; exp_stat[1] = 4'b0001;
        exp_stat[2] = 4'b0011; exp_stat[3] = 4'b0111;
        rst = 1'b1;
        bus.trig_i = 0; bus.trig_source_i = 0;
        bus.clear_i = 0; bus.clr_all_i = 0;
        step(2);
        rst = 1'b0;
        check_reset("rst");

        // single pulse, source 5
        bus.trig_i = 1; bus.trig_source_i = 4'h5;
        step(1);
        bus.trig_i = 0; bus.trig_source_i = 0;
        chk("p_digitize", 32'(bus.digitize_o), 1);
        chk("p_buffer", 32'(bus.digitize_buffer_o), 0);
        chk("p_status", 32'(bus.buffer_status_o), 4'b0000);
        chk("p_holds", 32'(bus.holds_o), 4'b0001);
        chk("p_source", 32'(bus.digitize_source_o), 4'h5);
        step(3);
        chk("p_dig_last", 32'(bus.digitize_o), 1);
        step(1);
        chk("p_dig_fall", 32'(bus.digitize_o), 0);
        chk("p_holdoff_busy", 32'(bus.busy_o), 1);
        step(7);
        chk("p_holdoff_end", 32'(bus.busy_o), 1);
        step(1);
        chk("p_idle", 32'(bus.busy_o), 0);

        // four spaced triggers from reset
        rst = 1; step(1); rst = 0;
        for (int i = 0; i < 4; i++) begin
            bus.trig_i = 1; bus.trig_source_i = 4'(i + 8);
            step(1);
            bus.trig_i = 0;
            chk("rr_buffer", 32'(bus.digitize_buffer_o), 32'(i));
            chk("rr_status", 32'(bus.buffer_status_o), 32'(exp_stat[i]));
            step(12);
        end
        chk("rr_full", 32'(bus.full_o), 1);
        bus.trig_i = 1;
        step(1);
        bus.trig_i = 0;
        chk("full_drop", 32'(bus.dropped_count_o), 1);
        chk("full_nodig", 32'(bus.digitize_o), 0);

        // clear and trigger in the same cycle
        bus.clear_i = 4'b0100; bus.trig_i = 1;
        step(1);
        bus.clear_i = 0; bus.trig_i = 0;
        chk("ct_buffer", 32'(bus.digitize_buffer_o), 2);
        chk("ct_status", 32'(bus.buffer_status_o), 4'b1011);
        chk("ct_holds", 32'(bus.holds_o), 4'b1111);
        step(12);

        // level trigger for 20 cycles
        bus.clear_i = 4'hF; step(1); bus.clear_i = 0;
        bus.trig_i = 1;
        step(13);
        chk("lvl_idle", 32'(bus.busy_o), 0);
        chk("lvl_drop13", 32'(bus.dropped_count_o), 13);
        step(1);
        chk("lvl_redig", 32'(bus.digitize_o), 1);
        chk("lvl_buffer", 32'(bus.digitize_buffer_o), 0);
        step(6);
        bus.trig_i = 0;
        chk("lvl_drop19", 32'(bus.dropped_count_o), 19);
        chk("lvl_holds", 32'(bus.holds_o), 4'b1001);
        step(12);

        // clr_all in the middle of a digitize
        rst = 1; step(1); rst = 0;
        bus.trig_i = 1; step(1); bus.trig_i = 0;
        step(12);
        bus.trig_i = 1; step(1); bus.trig_i = 0;
        chk("ca_pre_holds", 32'(bus.holds_o), 4'b0011);
        step(1);
        bus.clr_all_i = 1; step(1); bus.clr_all_i = 0;
        chk("ca_digitize", 32'(bus.digitize_o), 0);
        chk("ca_holds", 32'(bus.holds_o), 0);
        chk("ca_busy", 32'(bus.busy_o), 0);
        chk("ca_buffer_kept", 32'(bus.digitize_buffer_o), 1);
        step(1);
        bus.trig_i = 1; step(1); bus.trig_i = 0;
        chk("ca_next_buffer", 32'(bus.digitize_buffer_o), 2);
        chk("ca_next_dig", 32'(bus.digitize_o), 1);
        step(12);

        // saturate the drop counter with trig under clr_all
        bus.clr_all_i = 1; bus.trig_i = 1;
        step(1);
        chk("sat_first", 32'(bus.dropped_count_o), 1);
        chk("sat_nodig", 32'(bus.digitize_o), 0);
        step(65540);
        chk("sat_max", 32'(bus.dropped_count_o), 16'hFFFF);

        // reset overrides clr_all and trigger
        rst = 1; step(1);
        check_reset("rst2");
        rst = 0; bus.clr_all_i = 0; bus.trig_i = 0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
